// File: rtl/keypad_digit_capture_pkg.sv
// Shared definitions for the keypad capture front end: key FSM states,
// entry positions, per-position digit limits and the BCD helper.
package watch_pkg;

  localparam int DIGIT_W = 4;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2,
    RELEASE  = 2'd3
  } key_state_e;

  localparam logic [2:0] POS_H_TEN = 3'd0;
  localparam logic [2:0] POS_H_ONE = 3'd1;
  localparam logic [2:0] POS_M_TEN = 3'd2;
  localparam logic [2:0] POS_M_ONE = 3'd3;
  localparam logic [2:0] POS_S_TEN = 3'd4;
  localparam logic [2:0] POS_S_ONE = 3'd5;

  localparam logic [DIGIT_W-1:0] H_TEN_MAX       = 4'd2;
  localparam logic [DIGIT_W-1:0] H_ONE_MAX_AT_20 = 4'd3;
  localparam logic [DIGIT_W-1:0] MS_TEN_MAX      = 4'd5;

  // Index of the highest set key; callers only use it on one-hot vectors.
  function automatic logic [DIGIT_W-1:0] key_to_bcd(input logic [9:0] k);
    logic [DIGIT_W-1:0] r;
    r = '0;
    for (int i = 0; i < 10; i++) begin
      if (k[i]) r = DIGIT_W'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/keypad_digit_capture_sync.sv
// Two-flop synchroniser for raw asynchronous inputs, cleared by reset.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  // Two back-to-back flops; q is the metastability-filtered copy of d.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_digit_capture.sv
// Keypad digit capture: synchronises and debounces the 10-key pad and the
// set button, emits one BCD digit strobe per clean press and tracks the
// HH:MM:SS entry position. Define KEYPAD_RANGE_CHECK_EN to reject digits
// that cannot form a valid time at their entry position.
module keypad_digit_capture
  import watch_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 20,
  parameter int NUM_DIGITS   = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [9:0]         key_in,
  input  logic               set_btn,
  output logic [DIGIT_W-1:0] digit,
  output logic               digit_valid,
  output logic [2:0]         digit_idx,
  output logic               entry_active,
  output logic               entry_done,
  output logic               set_pulse,
  output logic               key_error
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [CNT_W-1:0] KEY_LAST = CNT_W'(DEBOUNCE_CYC - 1);
  // The set path counts one extra sample so its latency matches the key
  // path, which spends one cycle in IDLE latching the key before counting.
  localparam logic [CNT_W-1:0] SET_LAST = CNT_W'(DEBOUNCE_CYC);
  localparam logic [2:0] LAST_POS = 3'(NUM_DIGITS - 1);

  logic [9:0]         key_s;
  logic               set_s;
  key_state_e         key_state;
  logic [9:0]         key_q;
  logic [CNT_W-1:0]   key_cnt;
  logic               set_level;
  logic [CNT_W-1:0]   set_cnt;
  logic [2:0]         pos;
  logic               key_done;
  logic               key_onehot;
  logic               accept;
  logic               multi_err;
  logic               set_fire;
  logic               legal;
  logic [DIGIT_W-1:0] bcd;

  sync_2ff #(.WIDTH(10)) u_key_sync (
    .clk (clk),
    .rst (rst),
    .d   (key_in),
    .q   (key_s)
  );

  sync_2ff #(.WIDTH(1)) u_set_sync (
    .clk (clk),
    .rst (rst),
    .d   (set_btn),
    .q   (set_s)
  );

  assign key_onehot = (key_q & (key_q - 10'd1)) == 10'd0;
  assign key_done   = (key_state == DEBOUNCE) && (key_s == key_q) && (key_cnt == KEY_LAST);
  assign accept     = key_done && key_onehot;
  assign multi_err  = key_done && !key_onehot;
  assign bcd        = key_to_bcd(key_q);
  assign set_fire   = set_s && !set_level && (set_cnt == SET_LAST);

`ifdef KEYPAD_RANGE_CHECK_EN
  logic [1:0] h_ten;

  // Per-position legality; the hours-unit limit depends on the stored h_ten.
  always_comb begin
    legal = 1'b1;
    case (pos)
      POS_H_TEN: legal = (bcd <= H_TEN_MAX);
      POS_H_ONE: legal = (h_ten == 2'd2) ? (bcd <= H_ONE_MAX_AT_20) : 1'b1;
      POS_M_TEN: legal = (bcd <= MS_TEN_MAX);
      POS_S_TEN: legal = (bcd <= MS_TEN_MAX);
      default:   legal = 1'b1;
    endcase
  end

  // Remember the accepted tens-of-hours digit for the next position's limit.
  always_ff @(posedge clk) begin
    if (rst) begin
      h_ten <= 2'd0;
    end else if (!set_fire && accept && entry_active && legal && pos == POS_H_TEN) begin
      h_ten <= bcd[1:0];
    end
  end
`else
  assign legal = 1'b1;
`endif

  // Key FSM: one event per press, full debounce on both press and release.
  always_ff @(posedge clk) begin
    if (rst) begin
      key_state <= IDLE;
      key_q     <= '0;
      key_cnt   <= '0;
    end else begin
      case (key_state)
        IDLE: begin
          if (key_s != '0) begin
            key_q     <= key_s;
            key_cnt   <= '0;
            key_state <= DEBOUNCE;
          end
        end
        DEBOUNCE: begin
          if (key_s != key_q)          key_state <= IDLE;
          else if (key_cnt == KEY_LAST) key_state <= HELD;
          else                         key_cnt   <= key_cnt + 1'b1;
        end
        HELD: begin
          if (key_s == '0) begin
            key_cnt   <= '0;
            key_state <= RELEASE;
          end
        end
        default: begin
          if (key_s != '0)              key_state <= HELD;
          else if (key_cnt == KEY_LAST) key_state <= IDLE;
          else                          key_cnt   <= key_cnt + 1'b1;
        end
      endcase
    end
  end

  // Set button debouncer: the level only flips after a stable run of samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      set_level <= 1'b0;
      set_cnt   <= '0;
    end else if (set_s == set_level) begin
      set_cnt <= '0;
    end else if (set_cnt == SET_LAST) begin
      set_level <= set_s;
      set_cnt   <= '0;
    end else begin
      set_cnt <= set_cnt + 1'b1;
    end
  end

  // Output strobes and entry tracking; set wins over a same-cycle accept.
  // digit_idx follows pos one cycle late so the strobe shows its own slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      digit        <= '0;
      digit_valid  <= 1'b0;
      digit_idx    <= 3'd0;
      pos          <= 3'd0;
      entry_active <= 1'b1;
      entry_done   <= 1'b0;
      set_pulse    <= 1'b0;
      key_error    <= 1'b0;
    end else begin
      digit_valid <= 1'b0;
      entry_done  <= 1'b0;
      set_pulse   <= 1'b0;
      key_error   <= multi_err || (accept && entry_active && !legal);
      digit_idx   <= pos;
      if (set_fire) begin
        set_pulse    <= 1'b1;
        pos          <= 3'd0;
        digit_idx    <= 3'd0;
        entry_active <= 1'b1;
      end else if (accept && entry_active && legal) begin
        digit       <= bcd;
        digit_valid <= 1'b1;
        if (pos >= LAST_POS) begin
          pos          <= 3'd0;
          entry_done   <= 1'b1;
          entry_active <= 1'b0;
        end else begin
          pos <= pos + 3'd1;
        end
      end
    end
  end

endmodule

// File: doc/keypad_digit_capture.md
Name: keypad_digit_capture

Overview:
- Front-end stage that sits directly upstream of the digital watch counter/display block.
- Synchronises and debounces the raw 10-key numeric pad and the set-time button.
- Converts each clean key press into a single-cycle BCD digit strobe and tracks the 6-position HH:MM:SS entry sequence.
- The watch consumes digit/digit_valid/digit_idx instead of sampling raw keys every clock.

Parameters:
- DEBOUNCE_CYC, 20, stable-sample cycles required for press and for release (20 ms at 1 kHz clk); legal range 2..1023.
- NUM_DIGITS, 6, digits per entry sequence (h_ten, h_one, m_ten, m_one, s_ten, s_one).

Ports:
- clk  in  1  system clock, 1 kHz.
- rst  in  1  synchronous active-high reset.
- key_in  in  10  raw asynchronous keys; bit n = digit n, active-high.
- set_btn  in  1  raw asynchronous set-time button, active-high.
- digit  out  4  BCD value of the accepted key; holds its value until the next accept.
- digit_valid  out  1  one-cycle strobe; digit is valid.
- digit_idx  out  3  entry position of the current digit, 0..5.
- entry_active  out  1  entry sequence in progress.
- entry_done  out  1  one-cycle pulse, issued in the same cycle as the 6th digit_valid.
- set_pulse  out  1  one-cycle pulse on the debounced set_btn rising edge.
- key_error  out  1  one-cycle pulse when a press is rejected (multi-key or range).

Behaviour:
- Reset: clk and rst are the only clock and reset. On rst=1 at a clk edge, all of the following take effect at that edge:
  - digit=0, digit_valid=0, digit_idx=0, entry_done=0, set_pulse=0, key_error=0.
  - entry_active=1.
  - FSM=IDLE, counters=0, synchronisers=0.
- Synchronisers: key_in and set_btn each pass through 2 flops; key_s/set_s denote the synchronised values.
- Key FSM:
  - IDLE: if key_s!=0, latch key_q<=key_s, cnt<=0, go to DEBOUNCE.
  - DEBOUNCE: if key_s!=key_q, go to IDLE. Otherwise cnt++. At the edge where cnt==DEBOUNCE_CYC-1:
    - exactly one bit set in key_q: accept, then go to HELD;
    - more than one bit set: key_error pulse, then go to HELD.
  - HELD: wait for key_s==0, then cnt<=0 and go to RELEASE.
  - RELEASE: if key_s!=0, go to HELD. Otherwise cnt++; at cnt==DEBOUNCE_CYC-1, go to IDLE.
  - Result: exactly one event per physical press. No auto-repeat.
- Latency: with the key stable from clock edge 0, digit_valid is high in the cycle following edge DEBOUNCE_CYC+2.
- Accept:
  - If entry_active=1: digit<=index of key_q; digit_valid pulse; digit_idx presents the current position during the strobe, then increments.
  - Accept at position NUM_DIGITS-1: entry_done pulse, entry_active<=0, digit_idx<=0.
  - If entry_active=0: press is silently consumed; no strobes.
- Set button: separate counter with the same debounce rule. A debounced 0->1 transition gives set_pulse, digit_idx<=0, entry_active<=1. A held button gives no further pulses.
- Simultaneous set_pulse and accept in the same cycle: set wins. The digit is dropped (no digit_valid), digit_idx=0, entry_active=1.
- Reset mid-press: FSM returns to IDLE. A key still held after reset is debounced afresh and produces one event.
- digit_idx never exceeds NUM_DIGITS-1. All counters saturate and never wrap.

Optional Feature:
- Macro: KEYPAD_RANGE_CHECK_EN.
- Defined: per-position legality is enforced before accept:
  - pos0 (h_ten) <=2;
  - pos1 (h_one) <=3 if the accepted pos0 digit was 2, else <=9;
  - pos2 (m_ten) <=5; pos4 (s_ten) <=5.
  - Illegal digit: key_error pulse, no digit_valid, digit_idx unchanged. The block keeps a 2-bit copy of the accepted h_ten.
- Undefined: all digits 0..9 are accepted at every position, with no stored h_ten.

Decomposition:
- Package watch_pkg:
  - key FSM state enum (IDLE, DEBOUNCE, HELD, RELEASE);
  - position constants POS_H_TEN..POS_S_ONE;
  - per-position limits H_TEN_MAX=2, H_ONE_MAX_AT_20=3, MS_TEN_MAX=5;
  - digit width 4.
- Sub-module sync_2ff, parameterised width, instantiated for key_in (10) and set_btn (1).

Test Plan:
- DEBOUNCE_CYC=4, after reset, key_in=0x008 held 20 cycles -> digit_valid one cycle after edge 6, digit=3, digit_idx=0; no second strobe while held.
- key_in bit 5 toggled every 2 cycles for 30 cycles, then released -> no digit_valid, no key_error.
- Six clean presses 1,2,3,4,5,6 -> digit_idx 0..5 on the strobes; entry_done with the 6th; entry_active=0; a 7th press gives no strobe.
- key_in=0x011 stable -> key_error pulse, no digit_valid, digit_idx unchanged.
- set_btn press after entry_done -> set_pulse, entry_active=1, digit_idx=0. Set debounce completes in the same cycle as a digit accept -> no digit_valid, digit_idx=0.
- KEYPAD_RANGE_CHECK_EN defined: press 3 at pos0 -> key_error; then 2, then 4 -> key_error at pos1; then 3 -> digit_valid, digit_idx=1.
